dir_input_queue: RTL and testbench

DIR_INPUT_QUEUE -- requirements
Module: dir_input_queue

---
 rtl/dir_input_queue.sv | 111 +++++++++++
 tb/tb_dir_input_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dir_input_queue.sv
// Direction input queue: buffers filtered direction presses and commits one
// per game tick into the registered movement direction.
module dir_input_queue #(
  parameter int          QDEPTH   = 2,
  parameter logic [1:0]  INIT_DIR = 2'b11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up_pulse,
  input  logic       down_pulse,
  input  logic       left_pulse,
  input  logic       right_pulse,
  input  logic       tick,
  input  logic       game_run,
  input  logic       clear,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic [2:0] q_count,
  output logic       drop
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(QDEPTH - 1);

  typedef enum logic {STOP, RUN} state_t;

  state_t        state, state_next;
  logic          run_en;
  logic [1:0]    mem [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, tail_idx;
  logic [1:0]    cand, last_plan;
  logic          cand_valid, accept, do_push, do_pop, do_drop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= STOP;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      STOP: if (game_run)  state_next = RUN;
      RUN:  if (!game_run) state_next = STOP;
      default:             state_next = STOP;
    endcase
  end

  // Output logic
  always_comb begin
    run_en = (state == RUN);
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand_valid = up_pulse | down_pulse | left_pulse | right_pulse;
    cand       = 2'b11;
    if      (up_pulse)   cand = 2'b00;
    else if (down_pulse) cand = 2'b01;
    else if (left_pulse) cand = 2'b10;

    tail_idx  = (wr_ptr == '0) ? LAST_IDX : wr_ptr - PW'(1);
    last_plan = (q_count != 3'd0) ? mem[tail_idx] : dir;

    // Duplicate and reversal (bit 0 flipped) of the last planned move are ignored.
    accept  = run_en && cand_valid && (cand != last_plan) && (cand != (last_plan ^ 2'b01));
    do_push = accept && (q_count <  3'(QDEPTH));
    do_drop = accept && (q_count == 3'(QDEPTH));
    do_pop  = run_en && tick && (q_count != 3'd0);
  end

  // NOTE: queue storage has no reset; q_count guards every read, so stale
  // entries are never observed and the array can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      q_count     <= 3'd0;
      dir         <= INIT_DIR;
      dir_changed <= 1'b0;
      drop        <= 1'b0;
    end else if (clear) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      q_count     <= 3'd0;
      dir         <= INIT_DIR;
      dir_changed <= 1'b0;
      drop        <= 1'b0;
    end else begin
      dir_changed <= do_pop;
      drop        <= do_drop;
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        dir    <= mem[rd_ptr];
      end
      q_count <= q_count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

endmodule

// File: tb/tb_dir_input_queue.sv
// Randomized and directed bench for dir_input_queue, compared every cycle
// against a queue-based behavioural model.
module tb_dir_input_queue;

  localparam int         QD   = 2;
  localparam logic [1:0] INIT = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up_pulse, down_pulse, left_pulse, right_pulse;
  logic       tick, game_run, clear;
  logic [1:0] dir;
  logic       dir_changed;
  logic [2:0] q_count;
  logic       drop;

  dir_input_queue #(.QDEPTH(QD), .INIT_DIR(INIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .up_pulse    (up_pulse),
    .down_pulse  (down_pulse),
    .left_pulse  (left_pulse),
    .right_pulse (right_pulse),
    .tick        (tick),
    .game_run    (game_run),
    .clear       (clear),
    .dir         (dir),
    .dir_changed (dir_changed),
    .q_count     (q_count),
    .drop        (drop)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;

  // Reference model state
  logic [1:0] mq[$];
  logic [1:0] mdir;
  bit         mrun, mchg, mdrop;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    mdir  = INIT;
    mrun  = 1'b0;
    mchg  = 1'b0;
    mdrop = 1'b0;
  endtask

  // One clock edge of the model, using the inputs as sampled at that edge.
  task automatic model_edge();
    logic [1:0] c, last;
    bit         valid, acc, pop;
    if (clear) begin
      mq.delete();
      mdir  = INIT;
      mchg  = 1'b0;
      mdrop = 1'b0;
    end else begin
      mchg  = 1'b0;
      mdrop = 1'b0;
      if (mrun) begin
        valid = up_pulse || down_pulse || left_pulse || right_pulse;
        c = up_pulse ? 2'd0 : down_pulse ? 2'd1 : left_pulse ? 2'd2 : 2'd3;
        last = (mq.size() > 0) ? mq[mq.size()-1] : mdir;
        acc  = valid && c != last && !(c[1] == last[1] && c != last);
        pop  = tick && mq.size() > 0;
        if (acc && mq.size() == QD) mdrop = 1'b1;
        else if (acc) mq.push_back(c);
        if (pop) begin
          mdir = mq.pop_front();
          mchg = 1'b1;
        end
      end
    end
    mrun = game_run;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dir"},   dir,         mdir);
    check({tag, ".qcnt"},  q_count,     mq.size());
    check({tag, ".chg"},   dir_changed, mchg);
    check({tag, ".drop"},  drop,        mdrop);
  endtask

  task automatic cyc(input bit u, d, l, r, t, g, c, input string tag);
    up_pulse = u; down_pulse = d; left_pulse = l; right_pulse = r;
    tick = t; game_run = g; clear = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset();
    #5;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    @(posedge clk);
    #1;
    check_all("areset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    {up_pulse, down_pulse, left_pulse, right_pulse, tick, game_run, clear} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.dir", dir, 3);
    check("rst.qcnt", q_count, 0);
    check("rst.chg", dir_changed, 0);
    check("rst.drop", drop, 0);
    rst_n = 1'b1;

    // Start, push up, pop it
    cyc(0,0,0,0,0,1,0, "start");
    cyc(1,0,0,0,0,1,0, "push_up");
    check("push_up.q1", q_count, 1);
    cyc(0,0,0,0,1,1,0, "pop_up");
    check("pop_up.dir", dir, 0);
    check("pop_up.chg", dir_changed, 1);
    cyc(0,0,0,0,0,1,0, "idle");
    check("idle.chg", dir_changed, 0);

    // Reversal and duplicate rejected from dir=11
    cyc(0,0,0,0,0,1,1, "clr1");
    cyc(0,0,1,0,0,1,0, "rev");
    check("rev.q0", q_count, 0);
    cyc(0,0,0,1,0,1,0, "dup");
    check("dup.q0", q_count, 0);

    // Two queued, two pops
    cyc(1,0,0,0,0,1,0, "q_up");
    cyc(0,0,1,0,0,1,0, "q_left");
    check("q2", q_count, 2);
    cyc(0,0,0,0,1,1,0, "pop1");
    check("pop1.dir", dir, 0);
    cyc(0,0,0,0,1,1,0, "pop2");
    check("pop2.dir", dir, 2);
    check("pop2.chg", dir_changed, 1);

    // Full queue: drop, then drop with same-cycle pop
    cyc(0,0,0,0,0,1,1, "clr2");
    cyc(1,0,0,0,0,1,0, "f_up");
    cyc(0,0,1,0,0,1,0, "f_left");
    cyc(0,1,0,0,0,1,0, "f_down");
    check("full.drop", drop, 1);
    check("full.q2", q_count, 2);
    cyc(0,1,0,0,1,1,0, "f_down_tick");
    check("fdt.drop", drop, 1);
    check("fdt.dir", dir, 0);
    check("fdt.q1", q_count, 1);
    cyc(0,0,0,0,0,1,0, "f_idle");
    check("f_idle.drop", drop, 0);

    // Simultaneous presses: up wins
    cyc(0,0,0,0,0,1,1, "clr3");
    cyc(1,0,1,0,0,1,0, "prio");
    check("prio.q1", q_count, 1);
    cyc(0,0,0,0,1,1,0, "prio_pop");
    check("prio.dir", dir, 0);

    // STOP holds everything, clear empties
    cyc(0,0,0,0,0,1,1, "clr4");
    cyc(1,0,0,0,0,1,0, "s_up");
    cyc(0,0,1,0,0,0,0, "s_left");
    cyc(0,1,0,1,1,0,0, "stopped");
    check("stop.q2", q_count, 2);
    check("stop.dir", dir, 3);
    cyc(0,0,0,0,1,0,1, "stop_clr");
    check("clr.q0", q_count, 0);
    check("clr.dir", dir, 3);
    check("clr.chg", dir_changed, 0);

    // Randomized traffic with occasional clear and async reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        cyc($urandom_range(0,3) == 0, $urandom_range(0,3) == 0,
            $urandom_range(0,3) == 0, $urandom_range(0,3) == 0,
            $urandom_range(0,3) == 0, $urandom_range(0,19) != 0,
            $urandom_range(0,59) == 0, "rand");
      end
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
